uart_text_writer: RTL and testbench
===================================

# uart_text_writer

Converts the received UART byte stream into write commands for the 4×32 character RAM that feeds the VGA text generator. It sits between the `uart` receiver and `DualPortRAM` and owns the text cursor. It handles printable characters, CR/LF, backspace, line wrap, per-line clearing and full-screen clearing. It also exports the cursor position to the seven-segment display.

## Interface
Parameters:
- `START_COL`, 24: first visible column. A line runs `START_COL`…31, then 0…`START_COL-1` (column arithmetic is mod 32).
- `RESET_ROW`, 1: cursor row after reset and after any screen clear.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  received byte available. Held or single-cycle; one byte is consumed per handshake.
- `in_data`  in  8  received byte.
- `in_ready`  out  1  block can accept a byte. Equals `(state==IDLE) & ~clear` (combinational).
- `clear`  in  1  single-cycle screen-clear request (from the single-pulsed button).
- `wr_en`  out  1  RAM write strobe, registered.
- `wr_row`  out  2  RAM write row, registered.
- `wr_col`  out  5  RAM write column, registered.
- `wr_data`  out  8  RAM write data, registered.
- `cur_row`  out  2  current cursor row, registered.
- `cur_col`  out  5  current cursor column, registered.
- `busy`  out  1  high in `CLR_LINE` or `CLR_SCREEN`.

## Operation
States:
- `IDLE`: accepts input.
- `CLR_LINE`: writes 32 spaces to `cur_row`.
- `CLR_SCREEN`: writes 128 spaces, row-major, rows 0→3, cols 0→31.

Byte classes on handshake (`in_valid & in_ready`):
- **Printable, 0x20–0x7E:**
  - Write the byte at (`cur_row`,`cur_col`).
  - If `cur_col == START_COL-1 mod 32`: set col = `START_COL`, row = row+1 mod 4, go to `CLR_LINE`.
  - Otherwise col = col+1 mod 32.
- **CR 0x0D or LF 0x0A:** no data write. Set col = `START_COL`, row = row+1 mod 4 (3→0), go to `CLR_LINE`.
- **BS 0x08:**
  - If `cur_col == START_COL`: no-op.
  - Otherwise col = col−1 mod 32 (0→31), and write 0x20 at the new column.
- **All other bytes:** consumed and ignored; nothing written.

Clearing:
- `clear` sampled in `IDLE` → `CLR_SCREEN`. It has priority over a simultaneous `in_valid`; that byte is not consumed.
- `clear` during `CLR_LINE` → pending flag set. `CLR_SCREEN` is entered on the cycle after the last line write instead of `IDLE`.
- `clear` during `CLR_SCREEN` → scan restarts at cell (0,0).
- At the end of `CLR_SCREEN` the cursor is (`RESET_ROW`,`START_COL`) and the pending flag is cleared.

Reset:
- `reset_n` low forces state `CLR_SCREEN`, scan counter 0, `wr_en`=0, `wr_*`=0, cursor (`RESET_ROW`,`START_COL`), pending flag 0.
- The reset-time screen clear begins on the first clock edge after release.
- Reset asserted mid-operation aborts it immediately. No partial state survives.

## Timing
- Printable/BS accepted at edge N:
  - `wr_en`=1 with row/col/data valid during cycle N+1 (one-cycle latency).
  - `cur_*` updated at edge N.
  - `in_ready` stays high, so back-to-back bytes are accepted every cycle.
- Newline/wrap accepted at edge N:
  - State is `CLR_LINE` from N. Line writes occupy cycles N+1…N+32, cols 0…31.
  - `in_ready` returns high in cycle N+33.
  - A wrapping printable produces its own write in cycle N+1. The line clear then occupies N+2…N+33.
- `CLR_SCREEN`: exactly 128 write cycles, one cell per clock. `in_ready` is low throughout.
- `wr_en` is never high for more than one cycle per cell. No write is issued for ignored bytes.
- `busy` is registered and aligned with state.

## Structure
- Package `text_pkg` holds:
  - `TEXT_COLS`=32, `TEXT_ROWS`=4
  - `CHAR_CR`, `CHAR_LF`, `CHAR_BS`, `CHAR_SPACE`
  - the state enum `{IDLE, CLR_LINE, CLR_SCREEN}`
- Single module, no sub-module: one FSM plus a 7-bit scan counter. `CLR_LINE` uses the counter's low 5 bits.

## Test plan
- Reset release → 128 consecutive writes of 0x20 covering (0,0)…(3,31) in order, `in_ready`=0 throughout, then cursor (1,24) and `in_ready`=1.
- Send 0x41 in `IDLE` → next cycle `wr_en`=1, row 1, col 24, data 0x41; `cur_col`=25. Then send 0x42 → writes at col 25.
- Stream 32 printables from (1,24):
  - col passes 31→0, and the 32nd byte writes at col 23.
  - Cursor becomes (2,24), followed by 32 space writes to row 2.
  - `in_ready` stays low for those 32 cycles.
- Cursor (3,x), send 0x0D → no data write, cursor (0,24), row 0 cleared. Repeat with 0x0A for identical behaviour.
- At col 24, send 0x08 → no write. Then send 'A','B', 0x08 → write 0x20 at col 25, cursor col 25.
- Assert `clear` mid-`CLR_LINE` → line finishes, then 128-cell screen clear, cursor (1,24). Assert `clear` with `in_valid` in `IDLE` → byte not consumed, screen clear starts.

Source files
------------

// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_pkg
// Description : Shared constants, state encoding and helpers for the UART
//               text writer.
// Revision    : 1.0 - initial release
// ============================================================================
package text_pkg;

    localparam int TEXT_COLS = 32;
    localparam int TEXT_ROWS = 4;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_LINE   = 2'd1,
        CLR_SCREEN = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_text_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_text_writer_if
// Description : Byte-stream handshake into the text writer and the character
//               RAM write port out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_text_writer_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;

    // Byte source / RAM side of the writer
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_row,
        input  wr_col,
        input  wr_data
    );

    // The text writer itself
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_row,
        output wr_col,
        output wr_data
    );

endinterface
`default_nettype wire

// File: rtl/uart_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : uart_text_writer
// Description : Turns received UART bytes into character-RAM writes for a
//               4x32 text screen and owns the text cursor.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_text_writer
    import text_pkg::*;
#(
    parameter int START_COL = 24,
    parameter int RESET_ROW = 1
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    uart_text_writer_if.slave   bus,
    input  wire logic           clear,
    output logic [1:0]          cur_row,
    output logic [4:0]          cur_col,
    output logic                busy
);

    localparam logic [4:0] c_start_col = 5'(START_COL % TEXT_COLS);
    localparam logic [4:0] c_wrap_col  = 5'((START_COL + TEXT_COLS - 1) % TEXT_COLS);
    localparam logic [1:0] c_reset_row = 2'(RESET_ROW % TEXT_ROWS);

    state_t     r_state;
    logic [6:0] r_scan;
    logic       r_pending;
    logic       r_busy;
    logic       r_wr_en;
    logic [1:0] r_wr_row;
    logic [4:0] r_wr_col;
    logic [7:0] r_wr_data;
    logic [1:0] r_cur_row;
    logic [4:0] r_cur_col;

    logic [1:0] w_next_row;
    logic       w_is_newline;

    assign w_next_row   = r_cur_row + 2'd1;
    assign w_is_newline = (bus.in_data == CHAR_CR) || (bus.in_data == CHAR_LF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= CLR_SCREEN;
            r_scan    <= 7'd0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_wr_en   <= 1'b0;
            r_wr_row  <= 2'd0;
            r_wr_col  <= 5'd0;
            r_wr_data <= 8'd0;
            r_cur_row <= c_reset_row;
            r_cur_col <= c_start_col;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_state <= CLR_SCREEN;
                        r_busy  <= 1'b1;
                        r_scan  <= 7'd0;
                    end else if (bus.in_valid) begin
                        if (is_printable(bus.in_data)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_row  <= r_cur_row;
                            r_wr_col  <= r_cur_col;
                            r_wr_data <= bus.in_data;
                            if (r_cur_col == c_wrap_col) begin
                                // Scan starts at -1 so the character's own write gets a cycle
                                // before the line clear begins at column 0.
                                r_cur_col <= c_start_col;
                                r_cur_row <= w_next_row;
                                r_state   <= CLR_LINE;
                                r_busy    <= 1'b1;
                                r_scan    <= 7'h7F;
                            end else begin
                                r_cur_col <= r_cur_col + 5'd1;
                            end
                        end else if (w_is_newline) begin
                            // The first line-clear write goes out on the accepting edge.
                            r_wr_en   <= 1'b1;
                            r_wr_row  <= w_next_row;
                            r_wr_col  <= 5'd0;
                            r_wr_data <= CHAR_SPACE;
                            r_cur_col <= c_start_col;
                            r_cur_row <= w_next_row;
                            r_state   <= CLR_LINE;
                            r_busy    <= 1'b1;
                            r_scan    <= 7'd0;
                        end else if ((bus.in_data == CHAR_BS) && (r_cur_col != c_start_col)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_row  <= r_cur_row;
                            r_wr_col  <= r_cur_col - 5'd1;
                            r_wr_data <= CHAR_SPACE;
                            r_cur_col <= r_cur_col - 5'd1;
                        end
                    end
                end

                CLR_LINE: begin
                    if (clear) begin
                        r_pending <= 1'b1;
                    end
                    if (r_scan == 7'd31) begin
                        if (r_pending || clear) begin
                            r_state <= CLR_SCREEN;
                            r_scan  <= 7'd0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_row  <= r_cur_row;
                        r_wr_col  <= r_scan[4:0] + 5'd1;
                        r_wr_data <= CHAR_SPACE;
                        r_scan    <= r_scan + 7'd1;
                    end
                end

                CLR_SCREEN: begin
                    if (clear) begin
                        r_scan <= 7'd0;
                    end else if (r_wr_en && (r_scan == 7'd0)) begin
                        // Counter wrapped right after writing cell 127.
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_pending <= 1'b0;
                        r_cur_row <= c_reset_row;
                        r_cur_col <= c_start_col;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_row  <= r_scan[6:5];
                        r_wr_col  <= r_scan[4:0];
                        r_wr_data <= CHAR_SPACE;
                        r_scan    <= r_scan + 7'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == IDLE) & ~clear;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_row   = r_wr_row;
    assign bus.wr_col   = r_wr_col;
    assign bus.wr_data  = r_wr_data;
    assign cur_row      = r_cur_row;
    assign cur_col      = r_cur_col;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_text_writer
// Description : Self-checking bench for uart_text_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_text_writer;

    logic clk;
    logic reset_n;
    logic clear;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic busy;

    int n_checks;
    int n_fail;

    uart_text_writer_if bus ();

    uart_text_writer #(
        .START_COL(24),
        .RESET_ROW(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .clear   (clear),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       wr_en;
        logic [1:0] row;
        logic [4:0] col;
        logic [7:0] wdata;
        logic [1:0] crow;
        logic [4:0] ccol;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cell(input int k);
        check($sformatf("scr_cell%0d", k),
              {16'd0, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, bus.in_ready},
              {16'd0, 1'b1, 2'(k / 32), 5'(k % 32), 8'h20, 1'b0});
    endtask

    task automatic screen_scan(input int first);
        for (int k = first; k < 128; k++) begin
            tick();
            check_cell(k);
        end
        tick();
        check("scr_done", {bus.in_ready, busy, bus.wr_en, cur_row, cur_col},
              {1'b1, 1'b0, 1'b0, 2'd1, 5'd24});
    endtask

    // Newline from IDLE; optionally pulse clear at line-write index clear_at.
    task automatic newline(input logic [7:0] ch, input logic [1:0] row, input int clear_at);
        bus.in_valid = 1'b1;
        bus.in_data  = ch;
        tick();
        bus.in_valid = 1'b0;
        check("nl_first", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data},
              {1'b1, row, 5'd0, 8'h20});
        check("nl_cursor", {cur_row, cur_col, bus.in_ready, busy},
              {row, 5'd24, 1'b0, 1'b1});
        for (int j = 1; j < 32; j++) begin
            if (j == clear_at) clear = 1'b1;
            tick();
            clear = 1'b0;
            check($sformatf("nl_line%0d", j),
                  {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, bus.in_ready},
                  {1'b1, row, 5'(j), 8'h20, 1'b0});
        end
        tick();
        if (clear_at > 0) begin
            check("nl_pend", {bus.wr_en, bus.in_ready, busy}, {1'b0, 1'b0, 1'b1});
            screen_scan(0);
        end else begin
            check("nl_done", {bus.wr_en, bus.in_ready, busy}, {1'b0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        //             data   wr    row   col     wdata  crow  ccol
        vecs[0]  = '{8'h41, 1'b1, 2'd1, 5'd24, 8'h41, 2'd1, 5'd25};
        vecs[1]  = '{8'h42, 1'b1, 2'd1, 5'd25, 8'h42, 2'd1, 5'd26};
        vecs[2]  = '{8'h01, 1'b0, 2'd0, 5'd0,  8'h00, 2'd1, 5'd26};
        vecs[3]  = '{8'h08, 1'b1, 2'd1, 5'd25, 8'h20, 2'd1, 5'd25};
        vecs[4]  = '{8'h08, 1'b1, 2'd1, 5'd24, 8'h20, 2'd1, 5'd24};
        vecs[5]  = '{8'h08, 1'b0, 2'd0, 5'd0,  8'h00, 2'd1, 5'd24};
        vecs[6]  = '{8'h41, 1'b1, 2'd1, 5'd24, 8'h41, 2'd1, 5'd25};
        vecs[7]  = '{8'h42, 1'b1, 2'd1, 5'd25, 8'h42, 2'd1, 5'd26};
        vecs[8]  = '{8'h08, 1'b1, 2'd1, 5'd25, 8'h20, 2'd1, 5'd25};
        vecs[9]  = '{8'h1F, 1'b0, 2'd0, 5'd0,  8'h00, 2'd1, 5'd25};
        vecs[10] = '{8'h7F, 1'b0, 2'd0, 5'd0,  8'h00, 2'd1, 5'd25};
        vecs[11] = '{8'h7E, 1'b1, 2'd1, 5'd25, 8'h7E, 2'd1, 5'd26};
        vecs[12] = '{8'hC1, 1'b0, 2'd0, 5'd0,  8'h00, 2'd1, 5'd26};
        vecs[13] = '{8'h08, 1'b1, 2'd1, 5'd25, 8'h20, 2'd1, 5'd25};
        vecs[14] = '{8'h08, 1'b1, 2'd1, 5'd24, 8'h20, 2'd1, 5'd24};
        vecs[15] = '{8'h20, 1'b1, 2'd1, 5'd24, 8'h20, 2'd1, 5'd25};
        vecs[16] = '{8'h08, 1'b1, 2'd1, 5'd24, 8'h20, 2'd1, 5'd24};

        // Reset state and the power-on screen clear
        tick();
        tick();
        check("rst_state", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, busy, bus.in_ready, cur_row, cur_col},
              {1'b0, 2'd0, 5'd0, 8'h00, 1'b1, 1'b0, 2'd1, 5'd24});
        @(negedge clk);
        reset_n = 1'b1;
        screen_scan(0);

        // Back-to-back single bytes from the vector table
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vecs[i].data;
            tick();
            check($sformatf("vec%0d_wren", i), {31'd0, bus.wr_en}, {31'd0, vecs[i].wr_en});
            if (vecs[i].wr_en)
                check($sformatf("vec%0d_wr", i), {bus.wr_row, bus.wr_col, bus.wr_data},
                      {vecs[i].row, vecs[i].col, vecs[i].wdata});
            check($sformatf("vec%0d_cur", i), {cur_row, cur_col, bus.in_ready, busy},
                  {vecs[i].crow, vecs[i].ccol, 1'b1, 1'b0});
        end
        bus.in_valid = 1'b0;

        // 32 printables from (1,24): column wraps 31->0, last write at col 23
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h61 + 8'(i % 26);
            tick();
            check($sformatf("wrap_wr%0d", i), {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data},
                  {1'b1, 2'd1, 5'((24 + i) % 32), 8'h61 + 8'(i % 26)});
            if (i < 31)
                check($sformatf("wrap_cur%0d", i), {cur_row, cur_col, bus.in_ready},
                      {2'd1, 5'((25 + i) % 32), 1'b1});
            else
                check("wrap_cur_last", {cur_row, cur_col, bus.in_ready, busy},
                      {2'd2, 5'd24, 1'b0, 1'b1});
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 32; j++) begin
            tick();
            check($sformatf("wrap_line%0d", j),
                  {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, bus.in_ready},
                  {1'b1, 2'd2, 5'(j), 8'h20, 1'b0});
        end
        tick();
        check("wrap_done", {bus.wr_en, bus.in_ready, busy}, {1'b0, 1'b1, 1'b0});

        // CR/LF, including the 3->0 row wrap for both characters
        newline(8'h0A, 2'd3, -1);
        newline(8'h0D, 2'd0, -1);
        newline(8'h0A, 2'd1, -1);
        newline(8'h0A, 2'd2, -1);
        newline(8'h0A, 2'd3, -1);
        newline(8'h0A, 2'd0, -1);

        // Clear during a line clear: line completes, then full screen clear
        newline(8'h0A, 2'd1, 10);

        // Clear with a simultaneous byte in IDLE: byte is not consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        check("z_cur", {bus.wr_en, cur_row, cur_col}, {1'b1, 2'd1, 5'd25});
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h51;
        clear        = 1'b1;
        #1;
        check("clr_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_enter", {bus.wr_en, busy, cur_row, cur_col}, {1'b0, 1'b1, 2'd1, 5'd25});
        for (int k = 0; k < 5; k++) begin
            tick();
            check_cell(k);
        end

        // Clear during a screen clear restarts the scan at (0,0)
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_restart", {bus.wr_en, busy, bus.in_ready}, {1'b0, 1'b1, 1'b0});
        screen_scan(0);

        // Reset asserted mid line-clear aborts immediately
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h0A;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_abort", {bus.wr_en, bus.wr_row, bus.wr_col, busy, bus.in_ready, cur_row, cur_col},
              {1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 2'd1, 5'd24});
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_cell(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
